ex_stage_skid_reg: RTL and testbench
====================================

# ex_stage_skid_reg

Parametrised inter-stage pipeline register for the execute pipeline. It replaces the fixed two-lane EX1→EX2 latch with a generic N-lane, 2-entry skid register. The register uses a valid/ready handshake on both sides, a synchronous flush, and sticky exception squashing. It sits between any two execute stages (EX0/EX1/EX2/WB). Because of the skid entry, the upstream stage never sees a combinational path from downstream ready.

## Interface
Parameters:
- LANES, 2, issue lanes per beat; legal range 1..4.
- PAYLOAD_W, 160, per-lane payload bits (pc, inst, uop, imm, rj/rk/rd, result, result-valid), packed by the instantiating stage.
- BUBBLE_PAYLOAD, 0, value driven on out_payload lanes when no beat is valid.

Ports:
- clk  in  1  pipeline clock.
- aresetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all stored beats and of the exception latch.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  space available; registered, equals (count != 2).
- in_lane_valid  in  LANES  per-lane instruction valid.
- in_payload  in  LANES*PAYLOAD_W  lane i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- in_excp  in  1  beat carries an exception.
- in_ecode  in  7  exception code.
- in_badv  in  32  faulting address.
- out_valid  out  1  head beat valid.
- out_ready  in  1  downstream accepts the head.
- out_lane_valid  out  LANES  head lane valids.
- out_payload  out  LANES*PAYLOAD_W  head payload.
- out_excp  out  1  head exception flag.
- out_ecode  out  7  head exception code.
- out_badv  out  32  head badv.
- excp_pending  out  1  exception latch state.
- count  out  2  occupancy, 0..2.

## Operation
- Storage is a 2-entry FIFO: head slot H and skid slot S. All out_* signals are driven directly from H flops, with no combinational path from the inputs.
- Enqueue fire: in_valid & in_ready & ~flush.
- Dequeue fire: out_valid & out_ready & ~flush.
- Enqueue rules by count:
  - count 0: the incoming beat goes to H.
  - count 1 without dequeue: the incoming beat goes to S.
  - count 1 with dequeue: the incoming beat replaces H; count stays 1.
  - count 2: in_ready is 0, so no enqueue.
- Dequeue at count 2 moves S to H; count becomes 1.
- When H is empty:
  - out_valid, out_lane_valid, out_excp and out_ecode are 0.
  - out_badv is 0.
  - out_payload is BUBBLE_PAYLOAD.
- Exception latch: excp_pending is set on the enqueue fire of a beat with in_excp=1.
- While excp_pending=1, enqueued beats are accepted (in_ready still honoured) and discarded. They are not stored, count does not change, and no second exception is ever forwarded.
- excp_pending clears only on flush or reset.
- flush:
  - Next cycle count=0 and excp_pending=0; all slots are cleared to bubble values.
  - An in_valid beat in the flush cycle is dropped.
  - flush takes priority over simultaneous enqueue and dequeue.
- in_lane_valid and in_ecode/in_badv are stored verbatim. A beat with in_valid=1 and all lane valids 0 is still a stored beat.

## Timing
- Reset, asynchronous, active while aresetn=0: count=0, excp_pending=0, out_valid=0, out_lane_valid=0, out_excp=0, out_ecode=0, out_badv=0, out_payload=BUBBLE_PAYLOAD, in_ready=1.
- Latency: a beat enqueued in cycle t appears on out_* in cycle t+1 when count was 0.
- Throughput is one beat per cycle sustained when out_ready=1.
- in_ready depends only on registered count. After out_ready drops, up to one further beat is absorbed in S.
- Reset deasserted mid-stream: the first enqueue fire is the first cycle with aresetn=1 and in_valid=1.

## Structure
- Shared package pipe_pkg:
  - ECODE_W=7 and BADV_W=32.
  - typedef excp_t {flag, ecode, badv}.
  - The packed-lane slicing helper.
- One sub-module, stage_slot: a single-entry register holding lane_valid, payload and excp_t, with load and clear controls. It is instantiated twice (H, S).
- Top level holds count, excp_pending and the mux that selects S or the input into H.

## Test plan
- Streaming, LANES=2, out_ready=1: beats A(pc 0x1c000000), B(0x1c000008) on consecutive cycles -> out A at t+1, B at t+2; count never exceeds 1; in_ready stays 1.
- Backpressure: out_ready=0 while A, B, C are offered -> A,B stored, count=2, in_ready=0 and C held; raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Exception squash: beat E with in_excp=1, ecode=0x0b, badv=0x1c000010, then two normal beats -> only E forwarded (out_ecode=0x0b, out_badv=0x1c000010); excp_pending=1; count returns to 0.
- Flush at count=2 with simultaneous in_valid and out_ready -> next cycle out_valid=0, count=0, excp_pending=0, out_payload=BUBBLE_PAYLOAD; the next beat flows normally.
- Async reset asserted mid-stream at count=2 -> all outputs at reset values immediately, without waiting for a clock edge; in_ready=1.
- LANES=4, PAYLOAD_W=64: lane valids 4'b0101 with distinct per-lane payloads -> out_lane_valid=4'b0101 and lane slices bit-exact.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared execute-pipeline types: exception bundle carried alongside each beat
// and the packed-lane offset helper used wherever lanes are sliced.
package pipe_pkg;

    localparam int ECODE_W = 7;
    localparam int BADV_W  = 32;

    typedef struct packed {
        logic               flag;
        logic [ECODE_W-1:0] ecode;
        logic [BADV_W-1:0]  badv;
    } excp_t;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/ex_stage_skid_reg_if.sv
// Valid/ready beat bus between two execute stages; the register sits on the
// slave side, the producing/consuming stages on the master side.
interface ex_stage_skid_reg_if #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 160
);
    import pipe_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0]           in_lane_valid;
    logic [LANES*PAYLOAD_W-1:0] in_payload;
    logic                       in_excp;
    logic [ECODE_W-1:0]         in_ecode;
    logic [BADV_W-1:0]          in_badv;

    logic                       out_valid;
    logic                       out_ready;
    logic [LANES-1:0]           out_lane_valid;
    logic [LANES*PAYLOAD_W-1:0] out_payload;
    logic                       out_excp;
    logic [ECODE_W-1:0]         out_ecode;
    logic [BADV_W-1:0]          out_badv;

    modport master (
        output in_valid, in_lane_valid, in_payload, in_excp, in_ecode, in_badv, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_payload, out_excp, out_ecode, out_badv
    );

    modport slave (
        input  in_valid, in_lane_valid, in_payload, in_excp, in_ecode, in_badv, out_ready,
        output in_ready, out_valid, out_lane_valid, out_payload, out_excp, out_ecode, out_badv
    );

endinterface

// File: rtl/stage_slot.sv
// One beat of storage: lane valids, packed payload and exception bundle.
// clear wins over load and returns every field to its bubble value.
module stage_slot
    import pipe_pkg::*;
#(
    parameter int                   LANES          = 2,
    parameter int                   PAYLOAD_W      = 160,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = '0
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       load,
    input  logic                       clear,
    input  logic [LANES-1:0]           d_lane_valid,
    input  logic [LANES*PAYLOAD_W-1:0] d_payload,
    input  excp_t                      d_excp,
    output logic                       vld_p1,
    output logic [LANES-1:0]           lane_valid_p1,
    output logic [LANES*PAYLOAD_W-1:0] payload_p1,
    output excp_t                      excp_p1
);

    localparam logic [LANES*PAYLOAD_W-1:0] BUBBLE_BEAT = {LANES{BUBBLE_PAYLOAD}};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1        <= 1'b0;
            lane_valid_p1 <= '0;
            payload_p1    <= BUBBLE_BEAT;
            excp_p1       <= '0;
        end else if (clear) begin
            vld_p1        <= 1'b0;
            lane_valid_p1 <= '0;
            payload_p1    <= BUBBLE_BEAT;
            excp_p1       <= '0;
        end else if (load) begin
            vld_p1        <= 1'b1;
            lane_valid_p1 <= d_lane_valid;
            payload_p1    <= d_payload;
            excp_p1       <= d_excp;
        end
    end

endmodule

// File: rtl/ex_stage_skid_reg.sv
// Two-entry skid register between execute stages: head slot drives the
// outputs, skid slot absorbs the beat in flight when downstream stalls.
module ex_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int                   LANES          = 2,
    parameter int                   PAYLOAD_W      = 160,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = '0
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                flush,
    ex_stage_skid_reg_if.slave  bus,
    output logic                excp_pending,
    output logic [1:0]          count
);

    logic                       enq, deq, keep;
    logic                       h_load, h_clear, h_sel_s, s_load, s_clear;
    logic [1:0]                 count_d;
    logic                       in_ready_q;
    excp_t                      in_excp_s, h_d_excp;
    logic [LANES-1:0]           h_d_lane_valid;
    logic [LANES*PAYLOAD_W-1:0] h_d_payload;

    logic                       h_vld_p1, s_vld_p1;
    logic [LANES-1:0]           h_lane_valid_p1, s_lane_valid_p1;
    logic [LANES*PAYLOAD_W-1:0] h_payload_p1, s_payload_p1;
    excp_t                      h_excp_p1, s_excp_p1;

    assign enq       = bus.in_valid & in_ready_q & ~flush;
    assign deq       = h_vld_p1 & bus.out_ready & ~flush;
    // Once an exception is latched, accepted beats are swallowed, not stored.
    assign keep      = enq & ~excp_pending;
    assign in_excp_s = '{flag: bus.in_excp, ecode: bus.in_ecode, badv: bus.in_badv};

    always_comb begin
        h_load  = 1'b0;
        h_clear = 1'b0;
        h_sel_s = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        count_d = count;
        if (flush) begin
            h_clear = 1'b1;
            s_clear = 1'b1;
            count_d = 2'd0;
        end else begin
            unique case (count)
                2'd0: if (keep) begin
                    h_load  = 1'b1;
                    count_d = 2'd1;
                end
                2'd1: if (keep && deq) begin
                    h_load  = 1'b1;
                end else if (keep) begin
                    s_load  = 1'b1;
                    count_d = 2'd2;
                end else if (deq) begin
                    h_clear = 1'b1;
                    count_d = 2'd0;
                end
                2'd2: if (deq) begin
                    h_load  = 1'b1;
                    h_sel_s = 1'b1;
                    s_clear = 1'b1;
                    count_d = 2'd1;
                end
                default: begin
                    h_clear = 1'b1;
                    s_clear = 1'b1;
                    count_d = 2'd0;
                end
            endcase
        end
    end

    assign h_d_lane_valid = h_sel_s ? s_lane_valid_p1 : bus.in_lane_valid;
    assign h_d_payload    = h_sel_s ? s_payload_p1    : bus.in_payload;
    assign h_d_excp       = h_sel_s ? s_excp_p1       : in_excp_s;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count        <= 2'd0;
            in_ready_q   <= 1'b1;
            excp_pending <= 1'b0;
        end else begin
            count      <= count_d;
            in_ready_q <= (count_d != 2'd2);
            if (flush)
                excp_pending <= 1'b0;
            else if (enq && bus.in_excp)
                excp_pending <= 1'b1;
        end
    end

    // ---- p1: head and skid storage ----
    stage_slot #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .BUBBLE_PAYLOAD(BUBBLE_PAYLOAD)) u_head (
        .clk          (clk),
        .aresetn      (aresetn),
        .load         (h_load),
        .clear        (h_clear),
        .d_lane_valid (h_d_lane_valid),
        .d_payload    (h_d_payload),
        .d_excp       (h_d_excp),
        .vld_p1       (h_vld_p1),
        .lane_valid_p1(h_lane_valid_p1),
        .payload_p1   (h_payload_p1),
        .excp_p1      (h_excp_p1)
    );

    stage_slot #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .BUBBLE_PAYLOAD(BUBBLE_PAYLOAD)) u_skid (
        .clk          (clk),
        .aresetn      (aresetn),
        .load         (s_load),
        .clear        (s_clear),
        .d_lane_valid (bus.in_lane_valid),
        .d_payload    (bus.in_payload),
        .d_excp       (in_excp_s),
        .vld_p1       (s_vld_p1),
        .lane_valid_p1(s_lane_valid_p1),
        .payload_p1   (s_payload_p1),
        .excp_p1      (s_excp_p1)
    );

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = h_vld_p1;
    assign bus.out_lane_valid = h_lane_valid_p1;
    assign bus.out_payload    = h_payload_p1;
    assign bus.out_excp       = h_excp_p1.flag;
    assign bus.out_ecode      = h_excp_p1.ecode;
    assign bus.out_badv       = h_excp_p1.badv;

endmodule

// File: tb/tb_ex_stage_skid_reg.sv
// Scoreboard bench for ex_stage_skid_reg: a 2-lane instance exercised through
// streaming, backpressure, flush, exception and reset, plus a 4-lane instance.
module tb_ex_stage_skid_reg;
    import pipe_pkg::*;

    localparam int LA = 2;
    localparam int PA = 160;
    localparam int LB = 4;
    localparam int PB = 64;
    localparam logic [PA-1:0]    BUB_A      = {5{32'hB0B0CAFE}};
    localparam logic [LA*PA-1:0] BUB_A_BEAT = {LA{BUB_A}};

    typedef struct packed {
        logic [LA-1:0]    lv;
        logic [LA*PA-1:0] pay;
        logic             f;
        logic [6:0]       ec;
        logic [31:0]      bv;
    } beat_t;

    logic       clk = 1'b0;
    logic       aresetn = 1'b1;
    logic       flush_a = 1'b0;
    logic       flush_b = 1'b0;
    logic       excp_a, excp_b;
    logic [1:0] count_a, count_b;
    int         checks = 0;
    int         errors = 0;
    beat_t      sb[$];
    beat_t      mon_e;

    ex_stage_skid_reg_if #(.LANES(LA), .PAYLOAD_W(PA)) ia();
    ex_stage_skid_reg_if #(.LANES(LB), .PAYLOAD_W(PB)) ib();

    ex_stage_skid_reg #(.LANES(LA), .PAYLOAD_W(PA), .BUBBLE_PAYLOAD(BUB_A)) dut_a (
        .clk(clk), .aresetn(aresetn), .flush(flush_a), .bus(ia),
        .excp_pending(excp_a), .count(count_a)
    );

    ex_stage_skid_reg #(.LANES(LB), .PAYLOAD_W(PB), .BUBBLE_PAYLOAD(64'h0)) dut_b (
        .clk(clk), .aresetn(aresetn), .flush(flush_b), .bus(ib),
        .excp_pending(excp_b), .count(count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [LA*PA-1:0] act, input logic [LA*PA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mkb(input logic [31:0] pc, input logic [LA-1:0] lv,
                                  input logic f, input logic [6:0] ec, input logic [31:0] bv);
        beat_t b;
        b.lv  = lv;
        b.pay = {{5{pc + 32'h4}}, {5{pc}}};
        b.f   = f;
        b.ec  = ec;
        b.bv  = bv;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t b);
        ia.in_valid      = 1'b1;
        ia.in_lane_valid = b.lv;
        ia.in_payload    = b.pay;
        ia.in_excp       = b.f;
        ia.in_ecode      = b.ec;
        ia.in_badv       = b.bv;
    endtask

    task automatic idle();
        ia.in_valid = 1'b0;
        ia.in_excp  = 1'b0;
    endtask

    // Holds the beat until the handshake completes; store says whether the
    // register is expected to keep it (false while an exception is pending).
    task automatic send(input beat_t b, input bit store);
        bit ok;
        drive(b);
        for (int g = 0; g < 20; g++) begin
            ok = ia.in_ready;
            step();
            if (ok) begin
                if (store) sb.push_back(b);
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (aresetn && ia.out_valid === 1'b1 && ia.out_ready === 1'b1 && flush_a === 1'b0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 64'(ia.out_payload[31:0]), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_lane_valid", 64'(ia.out_lane_valid), 64'(mon_e.lv));
                chk_w("beat_payload", ia.out_payload, mon_e.pay);
                chk("beat_excp", 64'(ia.out_excp), 64'(mon_e.f));
                chk("beat_ecode", 64'(ia.out_ecode), 64'(mon_e.ec));
                chk("beat_badv", 64'(ia.out_badv), 64'(mon_e.bv));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] lanes_b [4];
        lanes_b[0] = 64'h1111_0000_0000_0001;
        lanes_b[1] = 64'h2222_0000_0000_0002;
        lanes_b[2] = 64'h3333_0000_0000_0003;
        lanes_b[3] = 64'h4444_0000_0000_0004;

        idle();
        ia.in_lane_valid = '0; ia.in_payload = '0; ia.in_ecode = '0; ia.in_badv = '0;
        ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_lane_valid = '0; ib.in_payload = '0;
        ib.in_excp = 1'b0; ib.in_ecode = '0; ib.in_badv = '0; ib.out_ready = 1'b0;

        #1 aresetn = 1'b0;
        #1;
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_excp_pending", 64'(excp_a), 64'd0);
        chk("rst_lane_valid", 64'(ia.out_lane_valid), 64'd0);
        chk_w("rst_payload", ia.out_payload, BUB_A_BEAT);
        chk("rst_ecode_badv", {25'd0, ia.out_excp, ia.out_ecode, ia.out_badv}, 64'd0);
        chk("rst_count_b", 64'(count_b), 64'd0);
        step(); step();
        aresetn = 1'b1;
        step();

        // 4-lane instance: sparse lane valids, every lane slice bit-exact
        ib.in_valid      = 1'b1;
        ib.in_lane_valid = 4'b0101;
        ib.in_payload    = {lanes_b[3], lanes_b[2], lanes_b[1], lanes_b[0]};
        step();
        ib.in_valid = 1'b0;
        chk("b_out_valid", 64'(ib.out_valid), 64'd1);
        chk("b_lane_valid", 64'(ib.out_lane_valid), 64'h5);
        for (int i = 0; i < 4; i++)
            chk("b_lane_slice", 64'(ib.out_payload >> lane_lsb(i, PB)), lanes_b[i]);

        // streaming
        ia.out_ready = 1'b1;
        send(mkb(32'h1c000000, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("stream_A_count", 64'(count_a), 64'd1);
        chk("stream_A_pc", 64'(ia.out_payload[31:0]), 64'h1c000000);
        send(mkb(32'h1c000008, 2'b01, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("stream_B_count", 64'(count_a), 64'd1);
        chk("stream_B_in_ready", 64'(ia.in_ready), 64'd1);
        chk("stream_B_pc", 64'(ia.out_payload[31:0]), 64'h1c000008);
        idle();
        step();
        chk("stream_drain_count", 64'(count_a), 64'd0);
        chk("stream_drain_valid", 64'(ia.out_valid), 64'd0);

        // backpressure: two stored, third held at the input
        ia.out_ready = 1'b0;
        send(mkb(32'h1c000020, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        send(mkb(32'h1c000028, 2'b10, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("bp_count2", 64'(count_a), 64'd2);
        chk("bp_in_ready0", 64'(ia.in_ready), 64'd0);
        drive(mkb(32'h1c000030, 2'b11, 1'b0, 7'h0, 32'h0));
        step(); step();
        chk("bp_held_count", 64'(count_a), 64'd2);
        chk("bp_head_pc", 64'(ia.out_payload[31:0]), 64'h1c000020);
        ia.out_ready = 1'b1;
        send(mkb(32'h1c000030, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        idle();
        step();
        chk("bp_drain_count", 64'(count_a), 64'd0);

        // flush at count 2 with simultaneous enqueue and dequeue
        ia.out_ready = 1'b0;
        send(mkb(32'h1c000040, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        send(mkb(32'h1c000048, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("fl_count2", 64'(count_a), 64'd2);
        drive(mkb(32'h1c000050, 2'b11, 1'b0, 7'h0, 32'h0));
        ia.out_ready = 1'b1;
        flush_a = 1'b1;
        step();
        sb.delete();
        flush_a = 1'b0;
        idle();
        chk("fl_out_valid", 64'(ia.out_valid), 64'd0);
        chk("fl_count", 64'(count_a), 64'd0);
        chk("fl_in_ready", 64'(ia.in_ready), 64'd1);
        chk_w("fl_payload", ia.out_payload, BUB_A_BEAT);
        send(mkb(32'h1c000058, 2'b01, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("fl_next_pc", 64'(ia.out_payload[31:0]), 64'h1c000058);
        idle();
        step();

        // exception squash
        send(mkb(32'h1c000010, 2'b11, 1'b1, 7'h0b, 32'h1c000010), 1'b1);
        chk("ex_pending", 64'(excp_a), 64'd1);
        chk("ex_ecode", 64'(ia.out_ecode), 64'h0b);
        chk("ex_badv", 64'(ia.out_badv), 64'h1c000010);
        send(mkb(32'h1c000018, 2'b11, 1'b0, 7'h0, 32'h0), 1'b0);
        chk("ex_squash_count", 64'(count_a), 64'd0);
        send(mkb(32'h1c000020, 2'b11, 1'b0, 7'h0, 32'h0), 1'b0);
        idle();
        step();
        chk("ex_after_valid", 64'(ia.out_valid), 64'd0);
        chk("ex_still_pending", 64'(excp_a), 64'd1);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk("ex_flush_clears", 64'(excp_a), 64'd0);
        send(mkb(32'h1c000060, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("ex_resume_valid", 64'(ia.out_valid), 64'd1);
        idle();
        step();

        // asynchronous reset mid-stream at count 2
        ia.out_ready = 1'b0;
        send(mkb(32'h1c000070, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        send(mkb(32'h1c000078, 2'b11, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("ar_count2", 64'(count_a), 64'd2);
        idle();
        #2 aresetn = 1'b0;
        #1;
        sb.delete();
        chk("ar_count", 64'(count_a), 64'd0);
        chk("ar_in_ready", 64'(ia.in_ready), 64'd1);
        chk("ar_out_valid", 64'(ia.out_valid), 64'd0);
        chk_w("ar_payload", ia.out_payload, BUB_A_BEAT);
        chk("ar_lane_ecode_badv", {23'd0, ia.out_lane_valid, ia.out_excp, ia.out_ecode, ia.out_badv}, 64'd0);
        step(); step();
        aresetn = 1'b1;
        ia.out_ready = 1'b1;
        send(mkb(32'h1c000080, 2'b10, 1'b0, 7'h0, 32'h0), 1'b1);
        chk("ar_resume_count", 64'(count_a), 64'd1);
        idle();
        step(); step();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
